// File: rtl/mems_mic_i2s_slave_tx.sv
// I2S slave transmitter for one MEMS-mic SD line: oversamples SCK/WS and shifts 24-bit L/R samples in 32-bit slots.
// Optional MIC_TX_TEST_PATTERN_EN adds test_mode_i, which replaces samples with a frame counter pattern.
module mems_mic_i2s_slave_tx #(
  parameter int DATA_W      = 24,
  parameter int SYNC_STAGES = 2,
  parameter int IDLE_DRIVE  = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sck_i,
  input  logic              ws_i,
  output logic              sd_o,
  output logic              sd_oe,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_left,
  input  logic [DATA_W-1:0] s_right,
  output logic              frame_start,
`ifdef MIC_TX_TEST_PATTERN_EN
  input  logic              test_mode_i,
`endif
  output logic              underrun
);
  localparam int CNT_W = $clog2(DATA_W + 1);

  typedef enum logic [1:0] {WAIT_SYNC, LOAD, SHIFT, IDLE} state_t;

  state_t                   state, state_nx;
  logic [SYNC_STAGES-1:0]   sck_sync, ws_sync;
  logic                     sck_hist, ws_r;
  logic                     sck_s, ws_s, rise, fall, slot_start;
  logic                     load_left, load_left_nx;
  logic [DATA_W-1:0]        shifter, shifter_nx;
  logic [CNT_W-1:0]         bit_cnt, bit_cnt_nx;
  logic [DATA_W-1:0]        act_r, act_r_nx;
  logic [DATA_W-1:0]        fb_l, fb_l_nx, fb_r, fb_r_nx;
  logic                     fb_full, fb_full_nx;
  logic                     sd_o_nx, sd_oe_nx, frame_start_nx, underrun_nx;
`ifdef MIC_TX_TEST_PATTERN_EN
  logic [DATA_W-1:0]        frame_cnt, frame_cnt_nx;
  assign s_ready = ~fb_full & ~test_mode_i;
`else
  assign s_ready = ~fb_full;
`endif

  assign sck_s      = sck_sync[SYNC_STAGES-1];
  assign ws_s       = ws_sync[SYNC_STAGES-1];
  assign rise       = sck_s & ~sck_hist;
  assign fall       = ~sck_s & sck_hist;
  // WS is captured on SCK rise; a change relative to the last capture opens a new slot.
  assign slot_start = rise & (ws_s != ws_r);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sck_sync <= '0;
      ws_sync  <= '0;
      sck_hist <= 1'b0;
      ws_r     <= 1'b0;
    end else begin
      sck_sync <= {sck_sync[SYNC_STAGES-2:0], sck_i};
      ws_sync  <= {ws_sync[SYNC_STAGES-2:0], ws_i};
      sck_hist <= sck_s;
      if (rise) ws_r <= ws_s;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= WAIT_SYNC;
      load_left   <= 1'b0;
      shifter     <= '0;
      bit_cnt     <= '0;
      act_r       <= '0;
      fb_l        <= '0;
      fb_r        <= '0;
      fb_full     <= 1'b0;
      sd_o        <= 1'b0;
      sd_oe       <= 1'b0;
      frame_start <= 1'b0;
      underrun    <= 1'b0;
`ifdef MIC_TX_TEST_PATTERN_EN
      frame_cnt   <= '0;
`endif
    end else begin
      state       <= state_nx;
      load_left   <= load_left_nx;
      shifter     <= shifter_nx;
      bit_cnt     <= bit_cnt_nx;
      act_r       <= act_r_nx;
      fb_l        <= fb_l_nx;
      fb_r        <= fb_r_nx;
      fb_full     <= fb_full_nx;
      sd_o        <= sd_o_nx;
      sd_oe       <= sd_oe_nx;
      frame_start <= frame_start_nx;
      underrun    <= underrun_nx;
`ifdef MIC_TX_TEST_PATTERN_EN
      frame_cnt   <= frame_cnt_nx;
`endif
    end
  end

  always_comb begin
    state_nx       = state;
    load_left_nx   = load_left;
    shifter_nx     = shifter;
    bit_cnt_nx     = bit_cnt;
    act_r_nx       = act_r;
    fb_l_nx        = fb_l;
    fb_r_nx        = fb_r;
    fb_full_nx     = fb_full;
    sd_o_nx        = sd_o;
    sd_oe_nx       = sd_oe;
    frame_start_nx = 1'b0;
    underrun_nx    = 1'b0;
`ifdef MIC_TX_TEST_PATTERN_EN
    frame_cnt_nx   = frame_cnt;
`endif
    // A handshake coinciding with a left load refills the buffer for the next frame.
    if (s_valid && s_ready) begin
      fb_l_nx    = s_left;
      fb_r_nx    = s_right;
      fb_full_nx = 1'b1;
    end
    case (state)
      WAIT_SYNC: begin
        sd_o_nx  = 1'b0;
        sd_oe_nx = 1'b0;
      end
      LOAD: begin
        bit_cnt_nx = '0;
        state_nx   = SHIFT;
        if (load_left) begin
          frame_start_nx = 1'b1;
`ifdef MIC_TX_TEST_PATTERN_EN
          if (test_mode_i) begin
            shifter_nx   = frame_cnt;
            act_r_nx     = ~frame_cnt;
            frame_cnt_nx = frame_cnt + 1'b1;
          end else
`endif
          if (fb_full) begin
            shifter_nx = fb_l;
            act_r_nx   = fb_r;
            fb_full_nx = 1'b0;
          end else begin
            shifter_nx  = '0;
            act_r_nx    = '0;
            underrun_nx = 1'b1;
          end
        end else begin
          shifter_nx = act_r;
        end
      end
      SHIFT: begin
        if (fall) begin
          if (bit_cnt == CNT_W'(DATA_W)) begin
            state_nx = IDLE;
            sd_o_nx  = 1'b0;
            sd_oe_nx = (IDLE_DRIVE != 0);
          end else begin
            sd_o_nx    = shifter[DATA_W-1];
            sd_oe_nx   = 1'b1;
            shifter_nx = {shifter[DATA_W-2:0], 1'b0};
            bit_cnt_nx = bit_cnt + 1'b1;
          end
        end
      end
      default: ;
    endcase
    // Any slot start (including a premature one) restarts; before sync only a left start counts.
    if (slot_start && (state != WAIT_SYNC || !ws_s)) begin
      state_nx     = LOAD;
      load_left_nx = ~ws_s;
    end
  end
endmodule

// File: tb/tb_mems_mic_i2s_slave_tx.sv
// Bench: I2S master + frame-level receiver model; checks per-slot samples, enable windows and pulse counts.
module tb_mems_mic_i2s_slave_tx;
  localparam int W    = 24;
  localparam int HALF = 50;

  typedef struct packed {
    logic [W-1:0] l;
    logic [W-1:0] r;
  } pair_t;

  logic         clk = 1'b0, rst_n = 1'b0, sck = 1'b0, ws = 1'b1;
  logic         sd_o, sd_oe, s_ready, frame_start, underrun;
  logic         s_valid = 1'b0;
  logic [W-1:0] s_left = '0, s_right = '0;

  mems_mic_i2s_slave_tx #(.DATA_W(W), .SYNC_STAGES(2), .IDLE_DRIVE(0)) dut (
    .clk(clk), .rst_n(rst_n), .sck_i(sck), .ws_i(ws),
    .sd_o(sd_o), .sd_oe(sd_oe),
    .s_valid(s_valid), .s_ready(s_ready), .s_left(s_left), .s_right(s_right),
    .frame_start(frame_start),
`ifdef MIC_TX_TEST_PATTERN_EN
    .test_mode_i(1'b0),
`endif
    .underrun(underrun)
  );

  always #5 clk = ~clk;

  int    n_tests = 0, n_fail = 0;
  int    fs_cnt = 0, ur_cnt = 0, exp_fs = 0, exp_ur = 0;
  pair_t push_q[$], acc_q[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Producer: holds s_valid while pairs are queued; a pair is accepted when s_ready is seen before the edge.
  initial forever begin
    @(negedge clk);
    if (rst_n && push_q.size() > 0) begin
      s_valid = 1'b1;
      s_left  = push_q[0].l;
      s_right = push_q[0].r;
      if (s_ready) acc_q.push_back(push_q.pop_front());
    end else begin
      s_valid = 1'b0;
    end
  end

  initial forever begin
    @(negedge clk);
    if (frame_start) fs_cnt++;
    if (underrun) ur_cnt++;
  end

  task automatic sck_cycle(input logic w, output logic d, output logic oe);
    sck = 1'b0;
    ws  = w;
    #HALF;
    sck = 1'b1;
    d   = sd_o;
    oe  = sd_oe;
    #HALF;
  endtask

  function automatic pair_t rnd_pair();
    logic [31:0] a, b;
    pair_t p;
    a = $urandom;
    b = $urandom;
    p.l = a[W-1:0];
    p.r = b[W-1:0];
    return p;
  endfunction

  // One frame: left slot then right slot. Bits are sampled on rises 1..W after the WS change.
  task automatic run_frame(input int len_l, input int len_r, input int n_push, input bit fixed,
                           input logic [W-1:0] fl, input logic [W-1:0] fr, input bit rst_mid,
                           input string nm);
    pair_t        e, p;
    logic [W-1:0] rx;
    int           oe_n;
    logic         d, oe;
    if (acc_q.size() > 0) e = acc_q.pop_front();
    else begin
      e = '0;
      exp_ur++;
    end
    exp_fs++;
    rx = '0; oe_n = 0;
    for (int i = 0; i < len_l; i++) begin
      sck_cycle(1'b0, d, oe);
      if (i >= 1 && i <= W) rx = {rx[W-2:0], d};
      if (i >= 1) oe_n += int'(oe);
    end
    if (len_l == 32) begin
      chk({nm, " left"}, 32'(rx), 32'(e.l));
      chk({nm, " left oe"}, oe_n, W);
    end
    rx = '0; oe_n = 0;
    for (int i = 0; i < len_r; i++) begin
      if (rst_mid && i == 8) begin
        #2 rst_n = 1'b0;
        acc_q.delete();
        push_q.delete();
        #36 rst_n = 1'b1;
        #2;
        oe_n = 0;
      end
      if (i == 16) begin
        for (int k = 0; k < n_push; k++) begin
          if (fixed) begin
            p.l = fl;
            p.r = fr;
          end else p = rnd_pair();
          push_q.push_back(p);
        end
      end
      sck_cycle(1'b1, d, oe);
      if (i >= 1 && i <= W) rx = {rx[W-2:0], d};
      if (i >= 1) oe_n += int'(oe);
    end
    if (rst_mid) chk({nm, " oe while resyncing"}, oe_n, 0);
    else if (len_r == 32) begin
      chk({nm, " right"}, 32'(rx), 32'(e.r));
      chk({nm, " right oe"}, oe_n, W);
    end
    chk({nm, " frame_start count"}, fs_cnt, exp_fs);
    chk({nm, " underrun count"}, ur_cnt, exp_ur);
  endtask

  initial begin
    logic d, oe;
    int   oe_n;
    pair_t p;
    #50;
    chk("reset sd_o", 32'(sd_o), 0);
    chk("reset sd_oe", 32'(sd_oe), 0);
    chk("reset s_ready", 32'(s_ready), 1);
    chk("reset frame_start", 32'(frame_start), 0);
    chk("reset underrun", 32'(underrun), 0);
    #52 rst_n = 1'b1;

    oe_n = 0;
    for (int i = 0; i < 8; i++) begin
      if (i == 2) begin
        p.l = 24'hA5A5A5;
        p.r = 24'h123456;
        push_q.push_back(p);
      end
      sck_cycle(1'b1, d, oe);
      oe_n += int'(oe);
    end
    chk("preamble oe", oe_n, 0);

    run_frame(32, 32, 60, 1'b0, '0, '0, 1'b0, "first");
    for (int f = 0; f < 60; f++) run_frame(32, 32, 0, 1'b0, '0, '0, 1'b0, "stream");
    run_frame(32, 32, 1, 1'b1, 24'h7FFFFF, 24'h800000, 1'b0, "underrun");
    run_frame(32, 32, 0, 1'b0, '0, '0, 1'b0, "maxmin");
    run_frame(32, 32, 1, 1'b1, 24'hABCDEF, 24'h012345, 1'b1, "reset mid");
    run_frame(32, 32, 1, 1'b0, '0, '0, 1'b0, "resync");
    run_frame(16, 32, 1, 1'b0, '0, '0, 1'b0, "short");
    run_frame(32, 32, 0, 1'b0, '0, '0, 1'b0, "after short");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
